// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package loader_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned WORD_W = BYTE_W * LANES;

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler: four accepted bytes form one word,
// the first byte landing in bits [7:0].
module byte_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    logic [WORD_W-1:0] shift_q;
    logic [LANE_W-1:0] lane_q;

    // Word as it stands once the current byte is shifted in
    assign word_c       = {byte_i, shift_q[WORD_W-1:BYTE_W]};
    assign word_valid_c = valid_i && !clear_i && (lane_q == LANE_W'(LANES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            lane_q  <= '0;
        end else if (clear_i) begin
            shift_q <= '0;
            lane_q  <= '0;
        end else if (valid_i) begin
            shift_q <= word_c;
            lane_q  <= lane_q + LANE_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction-memory
// writes and holds the core in reset until a complete, valid image is loaded.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MAX_WORDS   = 256,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              rx_valid,
    input  logic              rx_err,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    count_q,      count_d;
    logic [CNT_W-1:0]    word_idx_q,   word_idx_d;
    logic [IDLE_W-1:0]   idle_q,       idle_d;
    logic                imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q,  imem_addr_d;
    logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                err_q,        err_d;

    logic                in_run_c;
    logic                timeout_c;
    logic                accept_c;
    logic                clear_c;
    logic                word_valid_c;
    logic [WORD_W-1:0]   word_c;
    logic [CNT_W-1:0]    n_full_c;

    assign in_run_c  = (state_q == CNT_HI) || (state_q == DATA);
    assign timeout_c = in_run_c && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));
    assign n_full_c  = {rx_byte, count_q[BYTE_W-1:0]};

    // Only bytes that survive reload/rx_err/timeout priority reach the assembler
    assign accept_c = rx_valid && !reload && !rx_err && !timeout_c && (state_q == DATA);
    assign clear_c  = reload || (state_q != DATA);

    byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear_c),
        .valid_i      (accept_c),
        .byte_i       (rx_byte),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (reload) begin
            state_d    = CNT_LO;
            count_d    = '0;
            word_idx_d = '0;
        end else begin
            unique case (state_q)
                CNT_LO: begin
                    if (rx_err) begin
                        state_d = ERR;
                    end else if (rx_valid) begin
                        count_d = {{(CNT_W - BYTE_W){1'b0}}, rx_byte};
                        state_d = CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (rx_err || timeout_c) begin
                        state_d = ERR;
                    end else if (rx_valid) begin
                        count_d    = n_full_c;
                        word_idx_d = '0;
                        if ((n_full_c == '0) ||
                            ({1'b0, n_full_c} > (CNT_W + 1)'(MAX_WORDS))) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (rx_err || timeout_c) begin
                        state_d = ERR;
                    end else if (word_valid_c) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ADDR_W'(word_idx_q);
                        imem_wdata_d = word_c;
                        word_idx_d   = word_idx_q + CNT_W'(1);
                        if (word_idx_q == count_q - CNT_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = DONE;
                ERR:     state_d = ERR;
                default: state_d = ERR;
            endcase
        end

        // Idle counter runs only while a load is in flight and no byte arrives
        if (((state_d == CNT_HI) || (state_d == DATA)) && !rx_valid) begin
            idle_d = idle_q + IDLE_W'(1);
        end else begin
            idle_d = '0;
        end

        // Release the core one cycle after the final write becomes visible
        done_d       = (state_q == DONE) && (state_d == DONE);
        core_rst_n_d = done_d;
        busy_d       = (state_d == CNT_HI) || (state_d == DATA);
        err_d        = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= CNT_LO;
            count_q      <= '0;
            word_idx_q   <= '0;
            idle_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            idle_q       <= idle_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream boot stage for the RV32I core: receives a program image as a byte stream from the serial receiver and writes it, word by word, into the FETCH stage's instruction memory.
- Holds the core pipeline in reset until the image is complete.
- Releases the core only after a valid load; a malformed or stalled load raises an error and keeps the core halted.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest accepted image in words; must be ≤ 2**ADDR_W.
- TIMEOUT_CYC, 1000000, idle cycles allowed between bytes once a load has started.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_byte  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  single-cycle strobe, one per received byte.
- rx_err  in  1  framing-error strobe from the receiver.
- reload  in  1  debounced single-cycle request to restart loading.
- imem_we  out  1  instruction-memory write enable, one-cycle pulse.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- core_rst_n  out  1  active-low reset to the pipeline; 1 = core runs.
- busy  out  1  a load is in progress.
- done  out  1  image loaded and core released.
- err  out  1  load aborted.

Behaviour:
- Reset (rst=0, asynchronous): state=CNT_LO, all counters 0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, err=0.
- All outputs are registered.
- Stream format: 2-byte little-endian word count N, followed by 4*N bytes. Each word is little-endian: byte k goes to bits [8k+7:8k].
- State CNT_LO: wait for rx_valid; latch N[7:0]; go to CNT_HI.
- State CNT_HI: on rx_valid, latch N[15:8].
  - If the full N is 0 or greater than MAX_WORDS, go to ERR.
  - Otherwise go to DATA with word_idx=0 and byte_idx=0.
- State DATA: each rx_valid shifts the byte into the assembly register and increments byte_idx (mod 4).
  - On the 4th byte of a word, imem_we=1 on the NEXT cycle for exactly one cycle, with imem_addr=word_idx and imem_wdata=the assembled word.
  - word_idx then increments.
  - A byte arriving in the write cycle is accepted as byte 0 of the next word; no data is lost at one byte per cycle.
- Completion: when the write of word N-1 occurs, go to DONE on that same cycle. On the following cycle core_rst_n=1 and done=1. The core therefore leaves reset one cycle after the last write is visible.
- State DONE: rx_valid and rx_err are ignored; outputs hold.
- busy=1 in CNT_HI and DATA only. CNT_LO counts as idle.
- Timeout: in CNT_HI and DATA an idle counter increments every cycle and clears on rx_valid. When it reaches TIMEOUT_CYC-1, go to ERR.
- rx_err in CNT_LO, CNT_HI or DATA: go to ERR.
- State ERR: err=1, core_rst_n=0, busy=0. Remains until reload or rst. No imem writes; a pending write still completes.
- reload, in any state: next cycle state=CNT_LO, counters cleared, core_rst_n=0, done=0, err=0. Instruction-memory contents are untouched.
- Priority when events coincide in one cycle: reload > rx_err > timeout > rx_valid. A byte coinciding with reload or rx_err is dropped.
- Partial final word: the load never completes; the timeout catches it and goes to ERR.

Decomposition:
- Shared package loader_pkg: state enum {CNT_LO, CNT_HI, DATA, DONE, ERR}, the 16-bit count width constant, and byte/word-lane constants.
- One natural sub-module, byte_assembler: a 4-byte shift register with a 2-bit lane counter, a clear input, and a word_valid output.
- The timeout counter stays inline.

Test Plan:
- Load N=2: bytes 02 00 13 00 00 00 93 00 10 00 -> imem writes addr0=0x00000013 and addr1=0x00100093, one-cycle imem_we each; core_rst_n=1 and done=1 one cycle after the second write.
- Back-to-back: all bytes on consecutive cycles with N=3 -> exactly 3 writes with correct data, no byte lost across write cycles.
- Bad count: bytes 00 00, then separately 01 01 (N=257) with MAX_WORDS=256 -> ERR, err=1, core_rst_n=0, no imem_we.
- Timeout (TIMEOUT_CYC=16): N=1, then only 3 data bytes -> err=1 exactly 16 cycles after the last byte; no write.
- Reload and framing error: rx_err mid-DATA -> ERR. reload in the same cycle as rx_valid -> byte dropped, state CNT_LO, err=0. A full N=1 load then completes with done=1.
- Async reset: assert rst mid-DATA off a clock edge -> outputs are reset values immediately; after release, a fresh N=1 load succeeds.
